// File: rtl/sha3_sponge_if.sv
// Signal bundle between the byte source / keccak core / digest consumer and
// the sponge controller. The controller connects through the slave modport.
interface sha3_sponge_if #(
  parameter int D = 512,
  parameter int R = 1600 - 2*D
);
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_keep;
  logic         in_last;
  logic         in_ready;
  logic         core_reset;
  logic         core_enable;
  logic [R-1:0] core_message;
  logic [D-1:0] core_digest;
  logic [D-1:0] digest;
  logic         digest_valid;
  logic         digest_ready;

  modport slave (
    input  in_data, in_valid, in_keep, in_last, core_digest, digest_ready,
    output in_ready, core_reset, core_enable, core_message, digest, digest_valid
  );

  modport master (
    output in_data, in_valid, in_keep, in_last, core_digest, digest_ready,
    input  in_ready, core_reset, core_enable, core_message, digest, digest_valid
  );
endinterface

// File: rtl/sha3_sponge_ctrl.sv
// SHA3 sponge sequencer: packs bytes into rate blocks, applies 0x06..0x80
// padding, paces the keccak core's reset/enable and hands out the digest.
module sha3_sponge_ctrl #(
  parameter int D             = 512,
  parameter int R             = 1600 - 2*D,
  parameter int ABSORB_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  sha3_sponge_if.slave bus,
  output logic [2:0]   dbg_state
);
  localparam int R_BYTES = R / 8;
  localparam int IW      = $clog2(R_BYTES);
  localparam int CW      = $clog2(ABSORB_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(R_BYTES - 1);
  localparam logic [CW-1:0] LAST_CYC = CW'(ABSORB_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_INIT   = 3'd0,
    ST_FILL   = 3'd1,
    ST_PAD    = 3'd2,
    ST_ABSORB = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] idx;
  logic [CW-1:0] abs_cnt;
  logic          pend_pad;
  logic          final_blk;
  logic [R-1:0]  block;
  logic [D-1:0]  digest_q;
  logic          digest_valid_q;
  logic          beat;
  logic          at_end;
  logic          absorb_last;

  // Both handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; valid/data are held by the sender until that edge.
  assign beat        = bus.in_valid && (state == ST_FILL);
  assign at_end      = (idx == LAST_IDX);
  assign absorb_last = (abs_cnt == LAST_CYC);

  always_ff @(posedge clk) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: state_nxt = ST_FILL;
      ST_FILL: begin
        if (beat) begin
          if (bus.in_keep) begin
            if (at_end)           state_nxt = ST_ABSORB;
            else if (bus.in_last) state_nxt = ST_PAD;
          end else if (bus.in_last) begin
            state_nxt = ST_PAD;
          end
        end
      end
      ST_PAD: state_nxt = ST_ABSORB;
      ST_ABSORB: begin
        if (absorb_last) begin
          if (final_blk)     state_nxt = ST_DONE;
          else if (pend_pad) state_nxt = ST_PAD;
          else               state_nxt = ST_FILL;
        end
      end
      ST_DONE: begin
        if (digest_valid_q && bus.digest_ready) state_nxt = ST_INIT;
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  always_comb begin
    bus.in_ready    = 1'b0;
    bus.core_reset  = 1'b0;
    bus.core_enable = 1'b0;
    case (state)
      ST_INIT:   bus.core_reset  = 1'b1;
      ST_FILL:   bus.in_ready    = 1'b1;
      ST_ABSORB: bus.core_enable = 1'b1;
      default:   ;
    endcase
  end

  assign bus.core_message = block;
  assign bus.digest       = digest_q;
  assign bus.digest_valid = digest_valid_q;
  assign dbg_state        = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      idx            <= '0;
      abs_cnt        <= '0;
      pend_pad       <= 1'b0;
      final_blk      <= 1'b0;
      block          <= '0;
      digest_q       <= '0;
      digest_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          idx       <= '0;
          abs_cnt   <= '0;
          pend_pad  <= 1'b0;
          final_blk <= 1'b0;
          block     <= '0;
        end
        ST_FILL: begin
          if (beat && bus.in_keep) begin
            for (int k = 0; k < R_BYTES; k++) begin
              if (IW'(k) == idx) block[R-1-8*k -: 8] <= bus.in_data;
            end
            if (at_end) begin
              final_blk <= 1'b0;
              pend_pad  <= bus.in_last;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_PAD: begin
          // Bytes already holding message data (below idx) are left untouched.
          for (int k = 0; k < R_BYTES; k++) begin
            if (IW'(k) == idx)
              block[R-1-8*k -: 8] <= (k == R_BYTES - 1) ? 8'h86 : 8'h06;
            else if (IW'(k) > idx)
              block[R-1-8*k -: 8] <= (k == R_BYTES - 1) ? 8'h80 : 8'h00;
          end
          final_blk <= 1'b1;
          pend_pad  <= 1'b0;
        end
        ST_ABSORB: begin
          if (absorb_last) begin
            abs_cnt <= '0;
            idx     <= '0;
            if (!final_blk && !pend_pad) block <= '0;
          end else begin
            abs_cnt <= abs_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // The core's digest settles one cycle after its last enable.
          if (!digest_valid_q) begin
            digest_q       <= bus.core_digest;
            digest_valid_q <= 1'b1;
          end else if (bus.digest_ready) begin
            digest_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// Directed bench for sha3_sponge_ctrl with a stand-in keccak core that only
// reports the reference digest when the final padded block it sees is correct.
module tb_sha3_sponge_ctrl;
  localparam int D  = 512;
  localparam int R  = 1600 - 2*D;
  localparam int RB = R / 8;
  localparam int AC = 2;

  localparam logic [D-1:0] DIG_EMPTY = 512'ha69f73cca23a9ac5c8b567dc185a756e97c982164fe25859e0d1dcc1475c80a615b2123af1f5f94c11e3e9402c3ac558f500199d95b6d3e301758586281dcd26;
  localparam logic [D-1:0] DIG_ABC   = 512'hb751850b1a57168a5693cd924b6b096e08f621827444f70d884f5d0240d2712e10e116e9192af3c91a7ec57647e3934057340b4cf408d5a56592f8274eec53f0;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] dbg_state;

  sha3_sponge_if #(.D(D), .R(R)) bus ();

  sha3_sponge_ctrl #(.D(D), .R(R), .ABSORB_CYCLES(AC)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- stand-in core ----------------
  logic [D-1:0] stub_final;
  logic [R-1:0] stub_block;
  logic [D-1:0] stub_dig;
  int           stub_cnt;

  always @(posedge clk) begin
    if (bus.core_reset) begin
      stub_dig <= '0;
      stub_cnt <= 0;
    end else if (bus.core_enable) begin
      stub_cnt <= stub_cnt + 1;
      if (stub_cnt == AC - 1)
        stub_dig <= (bus.core_message === stub_block) ? stub_final : ~stub_final;
      else
        stub_dig <= {16{32'hdeadbeef}};
    end else begin
      stub_cnt <= 0;
    end
  end
  assign bus.core_digest = stub_dig;

  // ---------------- monitor ----------------
  logic [R-1:0] obs_q[$];
  int           len_q[$];
  logic [R-1:0] cur_blk;
  int           cur_len;
  logic         prev_en = 1'b0;
  int           crst_cycles, unstable, dv_cycles;

  always @(negedge clk) begin
    #1;
    if (!reset && bus.core_reset) crst_cycles++;
    if (bus.digest_valid) dv_cycles++;
    if (bus.core_enable) begin
      if (!prev_en) begin
        cur_blk = bus.core_message;
        cur_len = 0;
      end else if (bus.core_message !== cur_blk) begin
        unstable++;
      end
      cur_len++;
    end else if (prev_en) begin
      obs_q.push_back(cur_blk);
      len_q.push_back(cur_len);
    end
    prev_en = bus.core_enable;
  end

  // ---------------- scoreboard ----------------
  logic [R-1:0] exp_q[$];
  logic [7:0]   msg_q[$];
  int           n_checks = 0;
  int           n_pass   = 0;

  task automatic check(input string tag, input logic [R-1:0] obs, input logic [R-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic void model_blocks();
    int n;
    int nb;
    logic [R-1:0] blk;
    n  = msg_q.size();
    nb = n / RB + 1;
    exp_q.delete();
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int k = 0; k < RB; k++)
        if (b*RB + k < n) blk[R-1-8*k -: 8] = msg_q[b*RB + k];
      if (b == nb - 1) begin
        blk[R-1-8*(n % RB) -: 8] = blk[R-1-8*(n % RB) -: 8] | 8'h06;
        blk[7:0] = blk[7:0] | 8'h80;
      end
      exp_q.push_back(blk);
    end
  endfunction

  task automatic clear_mon();
    obs_q.delete();
    len_q.delete();
    crst_cycles = 0;
    unstable    = 0;
    dv_cycles   = 0;
  endtask

  task automatic check_blocks(input string tag);
    check({tag, "_windows"}, obs_q.size(), exp_q.size());
    check({tag, "_core_reset_cycles"}, crst_cycles, 1);
    check({tag, "_msg_unstable"}, unstable, 0);
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_block%0d", tag, i), obs_q[i], exp_q[i]);
      check($sformatf("%s_en_len%0d", tag, i), len_q[i], AC);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send_beat(input logic [7:0] d, input logic k, input logic l);
    int waited = 0;
    bus.in_data  = d;
    bus.in_keep  = k;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 400) check("beat_timeout", waited, 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic send_msg(input int idle_at);
    if (msg_q.size() == 0) send_beat(8'h00, 1'b0, 1'b1);
    for (int i = 0; i < msg_q.size(); i++) begin
      if (i == idle_at) send_beat(8'hff, 1'b0, 1'b0);
      send_beat(msg_q[i], 1'b1, i == msg_q.size() - 1);
    end
  endtask

  task automatic wait_digest(input string tag, output logic [D-1:0] d);
    int waited = 0;
    while (!bus.digest_valid && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 400) check({tag, "_digest_timeout"}, waited, 0);
    d = bus.digest;
  endtask

  task automatic take_digest(input string tag);
    bus.digest_ready = 1'b1;
    @(negedge clk);
    bus.digest_ready = 1'b0;
    check({tag, "_dv_cleared"}, bus.digest_valid, 0);
    clear_mon();
  endtask

  task automatic load_abc();
    msg_q.delete();
    msg_q.push_back(8'h61);
    msg_q.push_back(8'h62);
    msg_q.push_back(8'h63);
    model_blocks();
    stub_block = exp_q[exp_q.size()-1];
    stub_final = DIG_ABC;
  endtask

  task automatic load_random(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    model_blocks();
    stub_block = exp_q[exp_q.size()-1];
    stub_final = {8{64'h0123456789abcdef}} ^ D'(n);
  endtask

  // ---------------- directed sequence ----------------
  logic [D-1:0] got, abc_first;
  int           viol;

  initial begin
    reset            = 1'b1;
    bus.in_data      = '0;
    bus.in_valid     = 1'b0;
    bus.in_keep      = 1'b0;
    bus.in_last      = 1'b0;
    bus.digest_ready = 1'b0;
    stub_final       = '0;
    stub_block       = '0;
    clear_mon();
    repeat (3) @(negedge clk);

    check("rst_in_ready", bus.in_ready, 0);
    check("rst_core_enable", bus.core_enable, 0);
    check("rst_core_message", bus.core_message, 0);
    check("rst_digest_valid", bus.digest_valid, 0);
    check("rst_digest", bus.digest, 0);
    check("rst_state", dbg_state, 0);
    clear_mon();
    reset = 1'b0;

    // empty message
    msg_q.delete();
    model_blocks();
    stub_block = exp_q[0];
    stub_final = DIG_EMPTY;
    send_msg(-1);
    wait_digest("empty", got);
    check("empty_digest", got, DIG_EMPTY);
    check_blocks("empty");
    take_digest("empty");

    // "abc"
    load_abc();
    send_msg(-1);
    wait_digest("abc", got);
    abc_first = got;
    check("abc_digest", got, DIG_ABC);
    check("abc_first_byte", (obs_q.size() > 0) ? obs_q[0][R-1 -: 8] : 8'h00, 8'h61);
    check_blocks("abc");
    take_digest("abc");

    // 71 bytes with one ignored keep=0 beat inside: last byte becomes 0x86
    load_random(RB - 1);
    send_msg(10);
    wait_digest("m71", got);
    check("m71_digest", got, stub_final);
    check("m71_last_byte", (obs_q.size() > 0) ? obs_q[0][7:0] : 8'h00, 8'h86);
    check_blocks("m71");
    take_digest("m71");

    // 72 bytes: full block plus a separate padding block
    load_random(RB);
    send_msg(-1);
    wait_digest("m72", got);
    check("m72_digest", got, stub_final);
    check_blocks("m72");
    take_digest("m72");

    // reset mid-message, then "abc"
    load_random(30);
    for (int i = 0; i < 30; i++) send_beat(msg_q[i], 1'b1, 1'b0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_state", dbg_state, 0);
    check("midrst_core_message", bus.core_message, 0);
    check("midrst_dv_seen", dv_cycles, 0);
    clear_mon();
    reset = 1'b0;
    load_abc();
    send_msg(-1);
    wait_digest("midrst", got);
    check("midrst_digest", got, DIG_ABC);
    check_blocks("midrst");

    // backpressure on the digest, then a second "abc"
    viol = 0;
    repeat (10) begin
      @(negedge clk);
      if (!(bus.digest_valid === 1'b1 && bus.digest === got && bus.in_ready === 1'b0)) viol++;
    end
    check("hold_violations", viol, 0);
    take_digest("hold");
    load_abc();
    send_msg(-1);
    wait_digest("abc2", got);
    check("abc2_digest_same", got, abc_first);
    check_blocks("abc2");
    take_digest("abc2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
